// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory: rows in (one per cycle), columns out (one per cycle).
// Latency: first column is registered on the cycle after a block's 8th row is taken.
// Backpressure: in_ready drops only while both banks hold unread blocks; out_ready stalls the output register.
module dct_transpose_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  output logic             in_ready,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [2][8][8];

  logic [1:0] bank_full;
  logic       wr_bank;
  logic       rd_bank;
  logic [2:0] wr_row;
  logic [2:0] rd_col;

  logic do_wr;
  logic do_drop;
  logic do_ld;
  logic do_drain;

  assign in_ready = ~bank_full[wr_bank];
  assign do_wr    = en & in_valid & in_ready;
  assign do_drop  = en & in_valid & ~in_ready;
  assign do_ld    = en & bank_full[rd_bank] & (~out_valid | out_ready);
  assign do_drain = en & out_valid & out_ready & ~do_ld;

  // Storage is not reset; a reset simply forgets which rows are meaningful.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      mem[wr_bank][wr_row][0] <= I0;
      mem[wr_bank][wr_row][1] <= I1;
      mem[wr_bank][wr_row][2] <= I2;
      mem[wr_bank][wr_row][3] <= I3;
      mem[wr_bank][wr_row][4] <= I4;
      mem[wr_bank][wr_row][5] <= I5;
      mem[wr_bank][wr_row][6] <= I6;
      mem[wr_bank][wr_row][7] <= I7;
    end
  end

  // A completing write and a completing read always hit opposite banks,
  // so the set and clear of bank_full never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= 3'd0;
      rd_col    <= 3'd0;
      overflow  <= 1'b0;
    end else if (en) begin
      if (do_wr) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
        end
      end
      if (do_drop) begin
        overflow <= 1'b1;
      end
      if (do_ld) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) begin
          bank_full[rd_bank] <= 1'b0;
          rd_bank            <= ~rd_bank;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      O0 <= '0;
      O1 <= '0;
      O2 <= '0;
      O3 <= '0;
      O4 <= '0;
      O5 <= '0;
      O6 <= '0;
      O7 <= '0;
    end else if (do_ld) begin
      out_valid <= 1'b1;
      O0 <= mem[rd_bank][0][rd_col];
      O1 <= mem[rd_bank][1][rd_col];
      O2 <= mem[rd_bank][2][rd_col];
      O3 <= mem[rd_bank][3][rd_col];
      O4 <= mem[rd_bank][4][rd_col];
      O5 <= mem[rd_bank][5][rd_col];
      O6 <= mem[rd_bank][6][rd_col];
      O7 <= mem[rd_bank][7][rd_col];
    end else if (do_drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
